edge_detect_multi: RTL

Multi-channel, parametrised edge detector for the SPI/GPIO front ends. Each channel synchronises an asynchronous pin, optionally debounces it, and flags rising, falling, or both edges under a per-channel mode. It adds a sticky per-channel pending flag and one interrupt line, so the peripheral register block can service edges without polling single-cycle pulses.

---
 rtl/edge_detect_pkg.sv | 26 ++
 rtl/edge_detect_ch.sv | 129 ++++++++++++
 rtl/edge_detect_multi.sv | 64 ++++++
 3 files changed

// File: rtl/edge_detect_pkg.sv
// -----------------------------------------------------------------------------
// edge_detect_pkg
//   Shared types and constants for the multi-channel edge detector.
//   - edge_mode_t : per-channel edge selection encoding
//   - cnt_width() : width of the debounce counter for a given FILT_LEN
//                   ($clog2(FILT_LEN), never narrower than 1 bit)
//   The debounce filter is only built when EDGE_DETECT_FILTER_EN is defined.
// -----------------------------------------------------------------------------
package edge_detect_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    localparam int FILT_LEN_DEFAULT = 3;

    function automatic int cnt_width(input int filt_len);
        return (filt_len > 1) ? $clog2(filt_len) : 1;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(FILT_LEN_DEFAULT);

endpackage

// File: rtl/edge_detect_ch.sv
// -----------------------------------------------------------------------------
// edge_detect_ch
//   One edge-detector channel: synchroniser chain, optional debounce filter,
//   level / delayed-level flops, mode-selected edge decode and a sticky
//   pending flag.
//
//   Compile-time option: EDGE_DETECT_FILTER_EN
//     defined   : a FILT_LEN-cycle debounce counter sits between the
//                 synchroniser and the level flop.
//     undefined : the level is the synchroniser output directly; FILT_LEN is
//                 only range-checked and no counter flops exist.
//
//   Ports
//     clk        system clock
//     n_rst      asynchronous active-low reset
//     d_in       raw asynchronous pin level
//     edge_mode  00 off, 01 rising, 10 falling, 11 both
//     clr        write-one-to-clear for pending
//     d_edge     one-cycle edge pulse (combinational from level flops)
//     pending    sticky edge flag (registered)
// -----------------------------------------------------------------------------
module edge_detect_ch
    import edge_detect_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_LEN    = FILT_LEN_DEFAULT,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_in,
    input  logic [1:0] edge_mode,
    input  logic       clr,
    output logic       d_edge,
    output logic       pending
);

    if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_param
        $error("edge_detect_ch: need SYNC_STAGES >= 2 and FILT_LEN >= 1");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_out;
    logic                   w_lvl;
    logic                   r_lvl_d;
    logic                   r_pending;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_edge;

    // Synchroniser: bit 0 samples the pin, the top bit is the clean output.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_in};
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

`ifdef EDGE_DETECT_FILTER_EN
    localparam int             CNT_W   = cnt_width(FILT_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_lvl;

    // A new level is accepted only after it has differed from the current
    // level for FILT_LEN consecutive clocks; any return to the current level
    // restarts the count, so shorter glitches never reach r_lvl.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
            r_lvl <= RESET_LEVEL;
        end else if (w_sync_out != r_lvl) begin
            if (r_cnt == CNT_MAX) begin
                r_lvl <= w_sync_out;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign w_lvl = r_lvl;
`else
    assign w_lvl = w_sync_out;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_lvl_d <= RESET_LEVEL;
        end else begin
            r_lvl_d <= w_lvl;
        end
    end

    assign w_rise = ~r_lvl_d & w_lvl;
    assign w_fall = r_lvl_d & ~w_lvl;

    // Mode is applied at decode time, so a mode change affects the very next
    // level transition but never re-evaluates transitions already past.
    always_comb begin
        w_edge = 1'b0;
        case (edge_mode_t'(edge_mode))
            EDGE_OFF:  w_edge = 1'b0;
            EDGE_RISE: w_edge = w_rise;
            EDGE_FALL: w_edge = w_fall;
            EDGE_BOTH: w_edge = w_rise | w_fall;
            default:   w_edge = 1'b0;
        endcase
    end

    // A new edge takes priority over a simultaneous clear so no event is lost.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pending <= 1'b0;
        end else begin
            r_pending <= w_edge | (r_pending & ~clr);
        end
    end

    assign d_edge  = w_edge;
    assign pending = r_pending;

endmodule

// File: rtl/edge_detect_multi.sv
// -----------------------------------------------------------------------------
// edge_detect_multi
//   NUM_CH independent edge-detector channels with sticky pending flags and a
//   single interrupt line. Debounce filtering is compiled in only when
//   EDGE_DETECT_FILTER_EN is defined (see edge_detect_ch).
//
//   Ports
//     clk        system clock
//     n_rst      asynchronous active-low reset
//     d_in       [NUM_CH]   raw asynchronous pin levels
//     edge_mode  [2*NUM_CH] per channel: 00 off, 01 rise, 10 fall, 11 both
//     clr        [NUM_CH]   write-one-to-clear pulses for pending
//     irq_en     [NUM_CH]   per-channel interrupt enable
//     d_edge     [NUM_CH]   one-cycle edge pulses
//     pending    [NUM_CH]   sticky edge flags
//     irq                   OR of (pending & irq_en), combinational
// -----------------------------------------------------------------------------
module edge_detect_multi
    import edge_detect_pkg::*;
#(
    parameter int   NUM_CH      = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_LEN    = FILT_LEN_DEFAULT,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [NUM_CH-1:0]     d_in,
    input  logic [2*NUM_CH-1:0]   edge_mode,
    input  logic [NUM_CH-1:0]     clr,
    input  logic [NUM_CH-1:0]     irq_en,
    output logic [NUM_CH-1:0]     d_edge,
    output logic [NUM_CH-1:0]     pending,
    output logic                  irq
);

    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
        $error("edge_detect_multi: NUM_CH must be in 1..32");
    end

    logic [NUM_CH-1:0] w_d_edge;
    logic [NUM_CH-1:0] w_pending;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        edge_detect_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_ch (
            .clk       (clk),
            .n_rst     (n_rst),
            .d_in      (d_in[gi]),
            .edge_mode (edge_mode[2*gi +: 2]),
            .clr       (clr[gi]),
            .d_edge    (w_d_edge[gi]),
            .pending   (w_pending[gi])
        );
    end

    assign d_edge  = w_d_edge;
    assign pending = w_pending;
    assign irq     = |(w_pending & irq_en);

endmodule
